// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/write-back and drives datapath selects.
// Optional JAL support (LIGA state, RegDst=2 to $31) is enabled by defining CONTROLE_JAL_EN.
//
// state          | meaning
// BUSCA       0  | instruction fetch, waits on mem_pronta
// DECODIFICA  1  | decode, branch target precomputed into ALUOut
// END_MEM     2  | effective address for lw/sw
// LE_MEM      3  | data read, waits on mem_pronta
// WB_LW       4  | MDR written to rt
// ESCREVE_MEM 5  | data write, waits on mem_pronta
// EXEC_R      6  | R-type ALU operation
// WB_R        7  | ALUOut written to rd
// EXEC_I      8  | I-type ALU operation
// WB_I        9  | ALUOut written to rt
// DESVIO     10  | beq compare, PC conditionally loaded from ALUOut
// SALTO      11  | jump
// LIGA       12  | jal: PC+4 to $31 and jump (only with CONTROLE_JAL_EN)
// ERRO       15  | invalid opcode, held until reset
module unidade_controle_multiciclo #(
    parameter logic [5:0] OPC_R    = 6'b000000,
    parameter logic [5:0] OPC_LW   = 6'b100011,
    parameter logic [5:0] OPC_SW   = 6'b101011,
    parameter logic [5:0] OPC_BEQ  = 6'b000100,
    parameter logic [5:0] OPC_J    = 6'b000010,
    parameter logic [5:0] OPC_JAL  = 6'b000011,
    parameter logic [5:0] OPC_ADDI = 6'b001000,
    parameter logic [5:0] OPC_ANDI = 6'b001100,
    parameter logic [5:0] OPC_ORI  = 6'b001101,
    parameter logic [5:0] OPC_SLTI = 6'b001010
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_pronta,
    output logic [1:0] RegDst,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [1:0] MemtoReg,
    output logic       instr_fim,
    output logic       erro,
    output logic [3:0] estado
);

    typedef enum logic [3:0] {
        BUSCA       = 4'd0,
        DECODIFICA  = 4'd1,
        END_MEM     = 4'd2,
        LE_MEM      = 4'd3,
        WB_LW       = 4'd4,
        ESCREVE_MEM = 4'd5,
        EXEC_R      = 4'd6,
        WB_R        = 4'd7,
        EXEC_I      = 4'd8,
        WB_I        = 4'd9,
        DESVIO      = 4'd10,
        SALTO       = 4'd11,
`ifdef CONTROLE_JAL_EN
        LIGA        = 4'd12,
`endif
        ERRO        = 4'd15
    } estado_t;

    estado_t estado_q, estado_d;

    // funct reaches the ALU control directly and zero gates PCWriteCond in the datapath
    logic unused_entradas;
    assign unused_entradas = ^{funct, zero};

    logic eh_arit_i;
    assign eh_arit_i = (opcode == OPC_ADDI) || (opcode == OPC_ANDI) ||
                       (opcode == OPC_ORI)  || (opcode == OPC_SLTI);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado_q <= BUSCA;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d    = estado_q;
        RegDst      = 2'd0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'd0;
        ALUOp       = 2'd0;
        PCSource    = 2'd0;
        MemtoReg    = 2'd0;
        instr_fim   = 1'b0;
        erro        = 1'b0;

        case (estado_q)
            BUSCA: begin
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                if (mem_pronta) begin
                    IRWrite  = 1'b1;
                    PCWrite  = 1'b1;
                    estado_d = DECODIFICA;
                end
            end
            DECODIFICA: begin
                ALUSrcB = 2'd3;
                if (opcode == OPC_R) begin
                    estado_d = EXEC_R;
                end else if ((opcode == OPC_LW) || (opcode == OPC_SW)) begin
                    estado_d = END_MEM;
                end else if (eh_arit_i) begin
                    estado_d = EXEC_I;
                end else if (opcode == OPC_BEQ) begin
                    estado_d = DESVIO;
                end else if (opcode == OPC_J) begin
                    estado_d = SALTO;
`ifdef CONTROLE_JAL_EN
                end else if (opcode == OPC_JAL) begin
                    estado_d = LIGA;
`endif
                end else begin
                    estado_d = ERRO;
                end
            end
            END_MEM: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'd2;
                estado_d = (opcode == OPC_LW) ? LE_MEM : ESCREVE_MEM;
            end
            LE_MEM: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_pronta) begin
                    estado_d = WB_LW;
                end
            end
            WB_LW: begin
                RegWrite  = 1'b1;
                MemtoReg  = 2'd1;
                instr_fim = 1'b1;
                estado_d  = BUSCA;
            end
            ESCREVE_MEM: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_pronta) begin
                    instr_fim = 1'b1;
                    estado_d  = BUSCA;
                end
            end
            EXEC_R: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'd2;
                estado_d = WB_R;
            end
            WB_R: begin
                RegWrite  = 1'b1;
                RegDst    = 2'd1;
                instr_fim = 1'b1;
                estado_d  = BUSCA;
            end
            EXEC_I: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'd2;
                ALUOp    = 2'd3;
                estado_d = WB_I;
            end
            WB_I: begin
                RegWrite  = 1'b1;
                instr_fim = 1'b1;
                estado_d  = BUSCA;
            end
            DESVIO: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'd1;
                PCWriteCond = 1'b1;
                PCSource    = 2'd1;
                instr_fim   = 1'b1;
                estado_d    = BUSCA;
            end
            SALTO: begin
                PCWrite   = 1'b1;
                PCSource  = 2'd2;
                instr_fim = 1'b1;
                estado_d  = BUSCA;
            end
`ifdef CONTROLE_JAL_EN
            LIGA: begin
                RegWrite  = 1'b1;
                RegDst    = 2'd2;
                MemtoReg  = 2'd2;
                PCWrite   = 1'b1;
                PCSource  = 2'd2;
                instr_fim = 1'b1;
                estado_d  = BUSCA;
            end
`endif
            ERRO: begin
                erro     = 1'b1;
                estado_d = ERRO;
            end
            default: begin
                estado_d = BUSCA;
            end
        endcase
    end

    assign estado = estado_q;

endmodule
